rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
Parametrised general-purpose register file with two combinational read ports, one write port, optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending (scoreboard) bit. The scoreboard tells decode whether an operand is valid or still owed by an in-flight producer. It sits between decode (reads, pending set) and writeback (write, pending clear) in the core pipeline.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 8, number of architectural registers (2..64, need not be a power of 2)
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = reads see stored value only
ZERO_REG0, 0, 1 = register 0 reads as 0, ignores writes and never goes pending
ADDR_W (localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd0_addr  in  ADDR_W  read port 0 address
rd0_data  out  DATA_W  read port 0 data
rd0_ready  out  1  read port 0 operand valid (not pending, or bypassed this cycle)
rd1_addr  in  ADDR_W  read port 1 address
rd1_data  out  DATA_W  read port 1 data
rd1_ready  out  1  read port 1 operand valid
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
pend_set  in  1  issue strobe: mark pend_addr as owed by an in-flight producer
pend_addr  in  ADDR_W  destination of issued instruction
pend_vec  out  NUM_REGS  current pending bits, bit i = register i
err_waw  out  1  sticky: pend_set hit an already-pending register

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, err_waw 0. Reads during reset return 0 with ready 1. Reset mid-operation discards all in-flight pending state immediately.
- Write: at posedge clk with wr_en=1 and a legal address, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0. A write is dropped when wr_addr >= NUM_REGS, or when ZERO_REG0=1 and wr_addr=0.
- Read: combinational, zero-latency.
  - Normal read: rd_data = reg[addr].
  - Bypass: if BYPASS=1 and a non-dropped write targets addr in the same cycle, rd_data = wr_data.
  - Illegal address (>= NUM_REGS): rd_data = 0, ready = 1.
  - ZERO_REG0=1 and addr 0: rd_data = 0, ready = 1.
- Ready: rd_ready = !pending[addr], OR (BYPASS=1 and a non-dropped write to addr this cycle). With BYPASS=0, ready rises the cycle after the write.
- Pending set: at posedge with pend_set=1 and a legal address (not reg 0 when ZERO_REG0=1), pending[pend_addr] <= 1. Illegal addresses are ignored.
- Simultaneous pend_set and wr_en to the same address: set wins, so the bit stays 1. The write data is still stored and still bypassed, but ready is 0 next cycle because a newer producer owns the register.
- err_waw: set at posedge when pend_set targets a register whose pending bit is already 1, and no same-cycle write clears it. Held until reset.
- Writes to a non-pending register are legal; the data is stored and no error is raised.
- Both read ports are fully independent and may use the same address.
- pend_vec is a direct register output with no combinational input path.

Decomposition:
- Shared package (core_pkg): DATA_W and NUM_REGS defaults, and the ADDR_W derivation function.
- One natural sub-module, rf_read_port, instantiated twice. It takes the address, the storage array, the pending vector and the write-bypass signals, and produces data and ready.

Test Plan:
- Reset then read all addresses -> data 0, ready 1, pend_vec 0, err_waw 0. Assert rst_n low mid-run after writes -> outputs return to 0 asynchronously, before the next clock edge.
- Write 0xDEADBEEF to r3; next cycle read r3 on both ports -> both ports return 0xDEADBEEF. With BYPASS=1, reading r3 in the write cycle itself also returns 0xDEADBEEF.
- pend_set r5, then rd0_addr=5 -> rd0_ready=0 and pend_vec=8'b0010_0000. Write r5=0x12 -> same cycle: ready=1 and data 0x12 (BYPASS=1). Following cycle: pend_vec=0.
- pend_set r2 and wr_en r2 (0x55) in the same cycle -> next cycle pend_vec[2]=1, reg holds 0x55, rd_ready=0, err_waw=0.
- pend_set r4 twice without an intervening write -> err_waw=1 after the second edge and stays 1. Then write r4 -> pending clears, err_waw remains 1.
- ZERO_REG0=1, NUM_REGS=6: write 0xFF to r0 and to r7 -> both reads return 0 with ready 1. pend_set r0 -> pend_vec stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core defaults and register-address helpers for the register file slice.
package core_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefNumRegs = 8;

  function automatic int unsigned addr_w(int unsigned num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  // Legal means the register exists and is not the hardwired zero register.
  function automatic logic reg_legal(int unsigned addr, int unsigned num_regs, bit zero_reg0);
    return (addr < num_regs) && !(zero_reg0 && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: selects stored or forwarded data and reports operand readiness.
module rf_read_port
  import core_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned NUM_REGS  = DefNumRegs,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG0 = 1'b0,
  localparam int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]                addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              pend,
  input  logic                             wr_live,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W-1:0]                data,
  output logic                             ready
);

  // Missing registers and hardwired r0 read as an always-valid zero.
  always_comb begin
    data  = '0;
    ready = 1'b1;
    if (reg_legal(32'(addr), NUM_REGS, ZERO_REG0)) begin
      if (BYPASS && wr_live && (wr_addr == addr)) begin
        data = wr_data;
      end else begin
        data  = regs[addr];
        ready = !pend[addr];
      end
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with two read ports, one write port and a per-register pending scoreboard.
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned NUM_REGS  = DefNumRegs,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          ZERO_REG0 = 1'b0,
  localparam int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd0_addr,
  output logic [DATA_W-1:0]   rd0_data,
  output logic                rd0_ready,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd1_data,
  output logic                rd1_ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                pend_set,
  input  logic [ADDR_W-1:0]   pend_addr,
  output logic [NUM_REGS-1:0] pend_vec,
  output logic                err_waw
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             pend_q, pend_d;
  logic                            err_q, err_d;
  logic                            wr_live, pend_live;

  // Gating with rst_n keeps forwarded data off the read ports while in reset.
  assign wr_live   = rst_n && wr_en && reg_legal(32'(wr_addr), NUM_REGS, ZERO_REG0);
  assign pend_live = pend_set && reg_legal(32'(pend_addr), NUM_REGS, ZERO_REG0);

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    err_d  = err_q;
    if (wr_live) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // Set follows the clear so a newer producer keeps ownership on a collision.
    if (pend_live) begin
      if (pend_q[pend_addr] && !(wr_live && (wr_addr == pend_addr))) begin
        err_d = 1'b1;
      end
      pend_d[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign pend_vec = pend_q;
  assign err_waw  = err_q;

  rf_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS),
    .ZERO_REG0(ZERO_REG0)
  ) u_rd0 (
    .addr   (rd0_addr),
    .regs   (regs_q),
    .pend   (pend_q),
    .wr_live(wr_live),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .data   (rd0_data),
    .ready  (rd0_ready)
  );

  rf_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS),
    .ZERO_REG0(ZERO_REG0)
  ) u_rd1 (
    .addr   (rd1_addr),
    .regs   (regs_q),
    .pend   (pend_q),
    .wr_live(wr_live),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .data   (rd1_data),
    .ready  (rd1_ready)
  );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench: default register file plus a 6-entry hardwired-r0 variant.
module tb_rf_scoreboard;

  logic clk;
  logic rst_n;

  logic [2:0]  rd0_addr, rd1_addr, wr_addr, pend_addr;
  logic [31:0] rd0_data, rd1_data, wr_data;
  logic        rd0_ready, rd1_ready, wr_en, pend_set, err_waw;
  logic [7:0]  pend_vec;

  logic [2:0]  z_rd0_addr, z_rd1_addr, z_wr_addr, z_pend_addr;
  logic [31:0] z_rd0_data, z_rd1_data, z_wr_data;
  logic        z_rd0_ready, z_rd1_ready, z_wr_en, z_pend_set, z_err_waw;
  logic [5:0]  z_pend_vec;

  int n_pass;
  int n_total;

  rf_scoreboard #(
    .DATA_W   (32),
    .NUM_REGS (8),
    .BYPASS   (1'b1),
    .ZERO_REG0(1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd0_ready(rd0_ready),
    .rd1_addr (rd1_addr),
    .rd1_data (rd1_data),
    .rd1_ready(rd1_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pend_set (pend_set),
    .pend_addr(pend_addr),
    .pend_vec (pend_vec),
    .err_waw  (err_waw)
  );

  rf_scoreboard #(
    .DATA_W   (32),
    .NUM_REGS (6),
    .BYPASS   (1'b1),
    .ZERO_REG0(1'b1)
  ) dut_z (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd0_addr (z_rd0_addr),
    .rd0_data (z_rd0_data),
    .rd0_ready(z_rd0_ready),
    .rd1_addr (z_rd1_addr),
    .rd1_data (z_rd1_data),
    .rd1_ready(z_rd1_ready),
    .wr_en    (z_wr_en),
    .wr_addr  (z_wr_addr),
    .wr_data  (z_wr_data),
    .pend_set (z_pend_set),
    .pend_addr(z_pend_addr),
    .pend_vec (z_pend_vec),
    .err_waw  (z_err_waw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        ps;
    logic [2:0]  pa;
    logic [2:0]  a0;
    logic [2:0]  a1;
    logic [31:0] d0;
    logic        r0;
    logic [31:0] d1;
    logic        r1;
    logic [7:0]  pv;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] wa, logic [31:0] wd, logic ps,
                              logic [2:0] pa, logic [2:0] a0, logic [2:0] a1,
                              logic [31:0] d0, logic r0, logic [31:0] d1, logic r1,
                              logic [7:0] pv, logic err);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ps = ps; v.pa = pa; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.r0 = r0; v.d1 = d1; v.r1 = r1; v.pv = pv; v.err = err;
    return v;
  endfunction

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    {rd0_addr, rd1_addr, wr_addr, pend_addr, wr_data, wr_en, pend_set} = '0;
    {z_rd0_addr, z_rd1_addr, z_wr_addr, z_pend_addr, z_wr_data, z_wr_en, z_pend_set} = '0;

    // Reset state across all addresses.
    #1;
    for (int i = 0; i < 8; i++) begin
      rd0_addr = 3'(i);
      rd1_addr = 3'(7 - i);
      #1;
      chk("rst_rd0_data", 64'(rd0_data), 64'h0);
      chk("rst_rd0_ready", 64'(rd0_ready), 64'h1);
      chk("rst_rd1_data", 64'(rd1_data), 64'h0);
      chk("rst_rd1_ready", 64'(rd1_ready), 64'h1);
    end
    chk("rst_pend_vec", 64'(pend_vec), 64'h0);
    chk("rst_err_waw", 64'(err_waw), 64'h0);
    chk("rst_z_pend_vec", 64'(z_pend_vec), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //         we wa  wd            ps pa a0 a1  d0            r0  d1            r1  pv     err
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 3, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 3, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 5, 5, 3, 32'h0,        1, 32'hDEADBEEF, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 5, 3, 32'h0,        0, 32'hDEADBEEF, 1, 8'h20, 0));
    vecs.push_back(mk(1, 5, 32'h12,       0, 0, 5, 5, 32'h12,       1, 32'h12,       1, 8'h20, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 5, 0, 32'h12,       1, 32'h0,        1, 8'h00, 0));
    vecs.push_back(mk(1, 2, 32'h55,       1, 2, 2, 5, 32'h55,       1, 32'h12,       1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 2, 2, 32'h55,       0, 32'h55,       0, 8'h04, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 4, 4, 2, 32'h0,        1, 32'h55,       0, 8'h04, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 4, 4, 1, 32'h0,        0, 32'h0,        1, 8'h14, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 4, 3, 32'h0,        0, 32'hDEADBEEF, 1, 8'h14, 1));
    vecs.push_back(mk(1, 4, 32'hA5A5,     0, 0, 4, 2, 32'hA5A5,     1, 32'h55,       0, 8'h14, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 4, 3, 32'hA5A5,     1, 32'hDEADBEEF, 1, 8'h04, 1));
    vecs.push_back(mk(1, 7, 32'h77,       0, 0, 6, 7, 32'h0,        1, 32'h77,       1, 8'h04, 1));
    vecs.push_back(mk(1, 2, 32'h66,       0, 0, 2, 3, 32'h66,       1, 32'hDEADBEEF, 1, 8'h04, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 2, 7, 32'h66,       1, 32'h77,       1, 8'h00, 1));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      pend_set = vecs[i].ps; pend_addr = vecs[i].pa;
      rd0_addr = vecs[i].a0; rd1_addr = vecs[i].a1;
      #3;
      chk($sformatf("v%0d_rd0_data", i), 64'(rd0_data), 64'(vecs[i].d0));
      chk($sformatf("v%0d_rd0_ready", i), 64'(rd0_ready), 64'(vecs[i].r0));
      chk($sformatf("v%0d_rd1_data", i), 64'(rd1_data), 64'(vecs[i].d1));
      chk($sformatf("v%0d_rd1_ready", i), 64'(rd1_ready), 64'(vecs[i].r1));
      chk($sformatf("v%0d_pend_vec", i), 64'(pend_vec), 64'(vecs[i].pv));
      chk($sformatf("v%0d_err_waw", i), 64'(err_waw), 64'(vecs[i].err));
    end

    // Scoreboard: random writes queued, read back on both ports afterwards.
    for (int i = 0; i < 8; i++) begin
      wr_t w;
      @(posedge clk);
      #1;
      w.addr = 3'(i);
      w.data = $urandom;
      wr_en = 1'b1; wr_addr = w.addr; wr_data = w.data; pend_set = 1'b0;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    while (sb.size() > 0) begin
      wr_t w;
      w = sb.pop_front();
      rd0_addr = w.addr;
      rd1_addr = w.addr;
      #1;
      chk($sformatf("sb_rd0_r%0d", w.addr), 64'(rd0_data), 64'(w.data));
      chk($sformatf("sb_rd1_r%0d", w.addr), 64'(rd1_data), 64'(w.data));
      chk($sformatf("sb_rdy_r%0d", w.addr), 64'({rd0_ready, rd1_ready}), 64'h3);
    end

    // Hardwired r0, 6 registers: writes to r0 and r7 are dropped.
    @(posedge clk); #1;
    z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 32'hFF; z_rd0_addr = 3'd0; z_rd1_addr = 3'd7;
    #3;
    chk("z_r0_wrcyc", 64'({z_rd0_data, z_rd0_ready}), 64'h1);
    chk("z_r7_rd", 64'({z_rd1_data, z_rd1_ready}), 64'h1);
    @(posedge clk); #1;
    z_wr_addr = 3'd7; z_rd0_addr = 3'd7; z_rd1_addr = 3'd0;
    #3;
    chk("z_r7_wrcyc", 64'({z_rd0_data, z_rd0_ready}), 64'h1);
    @(posedge clk); #1;
    z_wr_en = 1'b0;
    #3;
    chk("z_r7_after", 64'({z_rd0_data, z_rd0_ready}), 64'h1);
    chk("z_r0_after", 64'({z_rd1_data, z_rd1_ready}), 64'h1);
    @(posedge clk); #1;
    z_pend_set = 1'b1; z_pend_addr = 3'd0;
    z_wr_en = 1'b1; z_wr_addr = 3'd5; z_wr_data = 32'h33; z_rd0_addr = 3'd5;
    #3;
    chk("z_r5_bypass", 64'({z_rd0_data, z_rd0_ready}), {31'h0, 32'h33, 1'b1});
    @(posedge clk); #1;
    z_wr_en = 1'b0;
    #3;
    chk("z_r5_stored", 64'({z_rd0_data, z_rd0_ready}), {31'h0, 32'h33, 1'b1});
    chk("z_pend_r0", 64'(z_pend_vec), 64'h0);
    @(posedge clk); #1;
    z_pend_addr = 3'd6; z_rd0_addr = 3'd0;
    #3;
    chk("z_err_r0_twice", 64'(z_err_waw), 64'h0);
    @(posedge clk); #1;
    z_pend_set = 1'b0;
    #3;
    chk("z_pend_illegal", 64'(z_pend_vec), 64'h0);
    chk("z_r0_ready", 64'({z_rd0_data, z_rd0_ready}), 64'h1);

    // Asynchronous reset mid-run clears state before the next edge.
    @(posedge clk); #1;
    pend_set = 1'b1; pend_addr = 3'd1; rd0_addr = 3'd1; rd1_addr = 3'd3;
    @(posedge clk); #1;
    pend_set = 1'b0;
    #1;
    chk("pre_rst_pend", 64'(pend_vec), 64'h02);
    chk("pre_rst_rd0_ready", 64'(rd0_ready), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pend", 64'(pend_vec), 64'h0);
    chk("async_rst_err", 64'(err_waw), 64'h0);
    chk("async_rst_rd0", 64'({rd0_data, rd0_ready}), 64'h1);
    chk("async_rst_rd1", 64'({rd1_data, rd1_ready}), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
